// File: rtl/ahb_burst_rr_scheduler_if.sv
// Request/grant bundle between the AHB masters and one slave-port burst scheduler.
interface ahb_burst_rr_scheduler_if #(
    parameter int unsigned MASTER_NUM = 2,
    parameter int unsigned MASTER_BIT = $clog2(MASTER_NUM)
);
    logic [MASTER_NUM-1:0]   hreq;
    logic [2*MASTER_NUM-1:0] htrans;
    logic [3*MASTER_NUM-1:0] hburst;
    logic                    hready;
    logic [MASTER_NUM-1:0]   hgrant;
    logic [MASTER_BIT-1:0]   hmaster;
    logic                    hlast;
    logic                    busy;

    modport master (
        output hreq, htrans, hburst, hready,
        input  hgrant, hmaster, hlast, busy
    );

    modport slave (
        input  hreq, htrans, hburst, hready,
        output hgrant, hmaster, hlast, busy
    );
endinterface

// File: rtl/ahb_burst_rr_scheduler.sv
// Round-robin slave-port scheduler that keeps the grant for a whole AHB burst
// (fixed bursts counted to length, undefined INCR capped at INCR_MAX_BEATS).
module ahb_burst_rr_scheduler #(
    parameter int unsigned MASTER_NUM     = 2,
    parameter int unsigned MASTER_BIT     = $clog2(MASTER_NUM),
    parameter int unsigned INCR_MAX_BEATS = 16,
    parameter int unsigned IDLE_TIMEOUT   = 8
) (
    input logic                     hclk,
    input logic                     hreset,
    ahb_burst_rr_scheduler_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANTED = 2'd1;
    localparam logic [1:0] S_BURST   = 2'd2;
    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam logic [4:0] INCR_CAP   = 5'(INCR_MAX_BEATS);
    localparam logic [3:0] IDLE_LIMIT = 4'(IDLE_TIMEOUT);
    localparam logic [MASTER_BIT-1:0] LAST_IDX = MASTER_BIT'(MASTER_NUM - 1);

    logic [1:0]            state, state_nxt;
    logic [MASTER_NUM-1:0] grant_q, grant_nxt;
    logic [MASTER_BIT-1:0] owner_q, owner_nxt, rr_ptr, owner_inc, winner;
    logic [4:0]            beat_cnt, beat_nxt, len_q, len_nxt, new_len;
    logic                  incr_q, incr_nxt;
    logic [3:0]            idle_cnt, idle_nxt, idle_inc;
    logic [1:0]            tr;
    logic [2:0]            bu;
    logic                  req_o, beat, start, rel, last_beat;

    function automatic logic [4:0] burst_len(input logic [2:0] b);
        case (b)
            3'd0:       burst_len = 5'd1;
            3'd1:       burst_len = INCR_CAP;
            3'd2, 3'd3: burst_len = 5'd4;
            3'd4, 3'd5: burst_len = 5'd8;
            default:    burst_len = 5'd16;
        endcase
    endfunction

    // Smallest rotational distance from ptr wins, so ptr itself is highest priority.
    function automatic logic [MASTER_BIT-1:0] rr_pick(input logic [MASTER_NUM-1:0] req,
                                                      input logic [MASTER_BIT-1:0] ptr);
        int unsigned p, d, best;
        p = 32'(ptr);
        best = MASTER_NUM;
        rr_pick = '0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            if (req[i]) begin
                d = (i >= p) ? i - p : i + MASTER_NUM - p;
                if (d < best) begin
                    best = d;
                    rr_pick = MASTER_BIT'(i);
                end
            end
        end
    endfunction

    always_comb begin
        tr = TR_IDLE;
        bu = '0;
        req_o = 1'b0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            if (owner_q == MASTER_BIT'(i)) begin
                tr = bus.htrans[2*i +: 2];
                bu = bus.hburst[3*i +: 3];
                req_o = bus.hreq[i];
            end
        end
    end

    assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        owner_nxt = owner_q;
        beat_nxt  = beat_cnt;
        len_nxt   = len_q;
        incr_nxt  = incr_q;
        idle_nxt  = idle_cnt;
        rel       = 1'b0;
        last_beat = 1'b0;
        start     = 1'b0;
        new_len   = burst_len(bu);
        idle_inc  = idle_cnt + 4'd1;
        beat      = (state != S_IDLE) && tr[1] && bus.hready;

        case (state)
            S_GRANTED: begin
                if (beat) begin
                    start = 1'b1;
                end else if (!req_o && !tr[1]) begin
                    rel = 1'b1;
                end else if (bus.hready && tr == TR_IDLE) begin
                    if (idle_inc == IDLE_LIMIT) rel = 1'b1;
                    else idle_nxt = idle_inc;
                end
            end
            S_BURST: begin
                if (beat) begin
                    idle_nxt = '0;
                    if (beat_cnt == len_q - 5'd1) begin
                        rel = 1'b1;
                        last_beat = 1'b1;
                    end else if (incr_q && tr == TR_NONSEQ) begin
                        start = 1'b1;
                    end else begin
                        beat_nxt = beat_cnt + 5'd1;
                    end
                end else if (bus.hready && tr == TR_IDLE) begin
                    if (!incr_q || !req_o || idle_inc == IDLE_LIMIT) rel = 1'b1;
                    else idle_nxt = idle_inc;
                end
            end
            default: ;
        endcase

        // First beat of a tenure, or a new INCR burst: a one-beat length ends the tenure here.
        if (start) begin
            idle_nxt = '0;
            if (new_len == 5'd1) begin
                rel = 1'b1;
                last_beat = 1'b1;
            end else begin
                state_nxt = S_BURST;
                beat_nxt  = 5'd1;
                len_nxt   = new_len;
                incr_nxt  = (bu == HB_INCR);
            end
        end

        winner = rr_pick(bus.hreq, rel ? owner_inc : rr_ptr);
        if (state == S_IDLE || rel) begin
            beat_nxt = '0;
            idle_nxt = '0;
            if (|bus.hreq) begin
                state_nxt = S_GRANTED;
                owner_nxt = winner;
                for (int unsigned i = 0; i < MASTER_NUM; i++) begin
                    grant_nxt[i] = (winner == MASTER_BIT'(i));
                end
            end else begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= S_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            len_q    <= '0;
            incr_q   <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_q  <= grant_nxt;
            owner_q  <= owner_nxt;
            beat_cnt <= beat_nxt;
            len_q    <= len_nxt;
            incr_q   <= incr_nxt;
            idle_cnt <= idle_nxt;
            if (rel) rr_ptr <= owner_inc;
        end
    end

    assign bus.hgrant  = grant_q;
    assign bus.hmaster = owner_q;
    assign bus.hlast   = last_beat;
    assign bus.busy    = (state != S_IDLE);
endmodule
